// File: rtl/stdout_arbiter.sv
// Round-robin, line-atomic arbiter feeding the single stdout UART TX byte port.
// Grant 1 cycle after request, byte on tx 1 cycle after accept; owner stalls via req_ready while the output byte is held.
module stdout_arbiter #(
  parameter int         N_REQ   = 4,
  parameter logic [7:0] EOL     = 8'h0A,
  parameter int         TIMEOUT = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [8*N_REQ-1:0]   req_data,
  input  logic [N_REQ-1:0]     req_valid,
  output logic [N_REQ-1:0]     req_ready,
  output logic [7:0]           tx_data,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  output logic [N_REQ-1:0]     grant,
  output logic                 busy
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t             state_q;
  logic [IW-1:0]      ptr_q;
  logic [N_REQ-1:0]   grant_q;
  logic [CW-1:0]      cnt_q;
  logic [7:0]         tx_data_q;
  logic               tx_valid_q;

  logic               slot_free;
  logic               own_valid;
  logic [7:0]         own_data;
  logic               accept;
  logic               pick_vld_d;
  logic [IW-1:0]      pick_idx_d;

  // While locked, ptr_q is the owner index and grant_q its one-hot form.
  assign slot_free = !tx_valid_q || tx_ready;
  assign own_valid = req_valid[ptr_q];
  assign own_data  = req_data[{ptr_q, 3'b000} +: 8];
  assign accept    = (state_q == LOCKED) && own_valid && slot_free;

  assign req_ready = ((state_q == LOCKED) && slot_free) ? grant_q : '0;
  assign tx_data   = tx_data_q;
  assign tx_valid  = tx_valid_q;
  assign grant     = grant_q;
  assign busy      = (|grant_q) || tx_valid_q;

  // Scan downward so the candidate nearest to ptr+1 is written last and wins.
  always_comb begin
    int idx;
    idx        = 0;
    pick_vld_d = 1'b0;
    pick_idx_d = ptr_q;
    for (int k = N_REQ; k >= 1; k--) begin
      idx = (int'(ptr_q) + k) % N_REQ;
      if (req_valid[IW'(idx)]) begin
        pick_vld_d = 1'b1;
        pick_idx_d = IW'(idx);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      ptr_q      <= IW'(N_REQ - 1);
      grant_q    <= '0;
      cnt_q      <= '0;
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
    end else begin
      if (accept) begin
        tx_data_q  <= own_data;
        tx_valid_q <= 1'b1;
      end else if (tx_ready) begin
        tx_valid_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (pick_vld_d) begin
            state_q <= LOCKED;
            ptr_q   <= pick_idx_d;
            grant_q <= N_REQ'(1) << pick_idx_d;
            cnt_q   <= '0;
          end
        end
        LOCKED: begin
          // A stalled-but-valid owner holds the counter: back-pressure never times out.
          if (accept) begin
            cnt_q <= '0;
            if (own_data == EOL) begin
              state_q <= IDLE;
              grant_q <= '0;
            end
          end else if (!own_valid) begin
            if (cnt_q >= CW'(TIMEOUT - 1)) begin
              state_q <= IDLE;
              grant_q <= '0;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          grant_q <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stdout_arbiter.sv
// Directed bench for stdout_arbiter: per-requester byte queues feed the DUT and a scoreboard checks the UART byte stream.
module tb_stdout_arbiter;

  localparam int N       = 4;
  localparam int TIMEOUT = 1024;

  logic             clk;
  logic             rst;
  logic [8*N-1:0]   req_data;
  logic [N-1:0]     req_valid;
  logic [N-1:0]     req_ready;
  logic [7:0]       tx_data;
  logic             tx_valid;
  logic             tx_ready;
  logic [N-1:0]     grant;
  logic             busy;

  stdout_arbiter #(.N_REQ(N), .EOL(8'h0A), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_data  (req_data),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .grant     (grant),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int           vec_cnt  = 0;
  int           miss_cnt = 0;
  int           cyc      = 0;
  int           txcnt    = 0;
  int           txr_mode = 0;   // 0: tx_ready high, 1: random, 2: held low
  int           last_acc [N];
  logic [7:0]   rq [N][$];
  logic [7:0]   exp_q [$];
  logic [N-1:0] glog [$];
  int           txcyc [$];
  logic [N-1:0] prev_grant = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    vec_cnt++;
    assert (got === want) else begin
      miss_cnt++;
      $error("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  task automatic redrive();
    for (int i = 0; i < N; i++) begin
      req_valid[i]        = (rq[i].size() > 0);
      req_data[8*i +: 8]  = (rq[i].size() > 0) ? rq[i][0] : 8'h00;
    end
  endtask

  // One clock: observe handshakes at the falling edge, then update stimulus just after the rising edge.
  task automatic tick();
    logic [N-1:0] f;
    @(negedge clk);
    f = req_valid & req_ready;
    for (int i = 0; i < N; i++) if (f[i]) last_acc[i] = cyc;
    if (tx_valid && tx_ready) begin
      txcnt++;
      txcyc.push_back(cyc);
      chk("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) chk("sb_byte", 32'(tx_data), 32'(exp_q.pop_front()));
    end
    if (grant != '0 && prev_grant == '0) glog.push_back(grant);
    prev_grant = grant;
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < N; i++) if (f[i]) void'(rq[i].pop_front());
    case (txr_mode)
      1:       tx_ready = 1'($urandom);
      2:       tx_ready = 1'b0;
      default: tx_ready = 1'b1;
    endcase
    redrive();
  endtask

  task automatic push_line(input int r, input logic [7:0] b);
    rq[r].push_back(b);
    exp_q.push_back(b);
  endtask

  task automatic wait_drain(input int limit);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < limit) begin
      tick();
      n++;
    end
    chk("drain", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_tx_valid"},  32'(tx_valid),  32'd0);
    chk({tag, "_tx_data"},   32'(tx_data),   32'd0);
    chk({tag, "_grant"},     32'(grant),     32'd0);
    chk({tag, "_busy"},      32'(busy),      32'd0);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd0);
  endtask

  initial begin
    int n;
    int base;
    int clear_cyc;
    logic [7:0] b;

    for (int i = 0; i < N; i++) last_acc[i] = 0;

    // Reset held with random inputs.
    rst       = 1'b1;
    req_data  = $urandom;
    req_valid = N'($urandom);
    tx_ready  = 1'($urandom);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      req_data  = $urandom;
      req_valid = N'($urandom);
      tx_ready  = 1'($urandom);
      #1;
      chk_reset_outputs("rst");
    end

    // Release; every requester offers two single-byte EOL lines.
    @(posedge clk);
    #1;
    rst      = 1'b0;
    tx_ready = 1'b1;
    txr_mode = 0;
    cyc      = 0;
    for (int r = 0; r < N; r++) push_line(r, 8'h0A);
    for (int r = 0; r < N; r++) push_line(r, 8'h0A);
    redrive();
    chk("arb_c0_grant", 32'(grant), 32'd0);
    tick();
    chk("arb_c1_grant", 32'(grant), 32'b0001);
    chk("arb_c1_ready", 32'(req_ready), 32'b0001);
    tick();
    chk("arb_c2_tx_valid", 32'(tx_valid), 32'd1);
    chk("arb_c2_tx_data", 32'(tx_data), 32'h0A);
    chk("arb_c2_eol_idle", 32'(grant), 32'd0);
    wait_drain(60);
    chk("rr_count", 32'(glog.size()), 32'd8);
    for (int k = 0; k < 8 && k < glog.size(); k++)
      chk($sformatf("rr_grant%0d", k), 32'(glog[k]), 32'(1 << (k % N)));

    // Line atomicity: "AB\n" on req0 and "CD\n" on req1, both pending together.
    glog.delete();
    txcyc.delete();
    push_line(0, 8'h41); push_line(0, 8'h42); push_line(0, 8'h0A);
    push_line(1, 8'h43); push_line(1, 8'h44); push_line(1, 8'h0A);
    redrive();
    wait_drain(40);
    chk("line_grants", 32'(glog.size()), 32'd2);
    if (glog.size() >= 2) begin
      chk("line_grant0", 32'(glog[0]), 32'b0001);
      chk("line_grant1", 32'(glog[1]), 32'b0010);
    end
    chk("line_txcnt", 32'(txcyc.size()), 32'd6);
    if (txcyc.size() >= 4) begin
      chk("line_back2back", 32'(txcyc[1] - txcyc[0]), 32'd1);
      chk("line_eol_gap", 32'(txcyc[3] - txcyc[2]), 32'd2);
    end

    // Timeout: req2 sends one byte without EOL and goes quiet while req3 waits.
    glog.delete();
    push_line(2, 8'h55);
    push_line(3, 8'h66); push_line(3, 8'h0A);
    redrive();
    n = 0;
    while (!grant[2] && n < 10) begin tick(); n++; end
    chk("to_granted", 32'(grant), 32'b0100);
    n = 0;
    while (grant[2] && n < 2*TIMEOUT + 10) begin tick(); n++; end
    clear_cyc = cyc;
    // The accept edge closes cycle last_acc; grant drops TIMEOUT edges after it.
    chk("to_release", 32'(clear_cyc - (last_acc[2] + 1)), 32'(TIMEOUT));
    tick();
    chk("to_next_grant", 32'(grant), 32'b1000);
    wait_drain(20);

    // Back-pressure: 16-byte line under random tx_ready with one long stall.
    glog.delete();
    for (int k = 0; k < 15; k++) begin
      b = 8'($urandom_range(8'h20, 8'h7E));
      push_line(0, b);
    end
    push_line(0, 8'h0A);
    redrive();
    txr_mode = 1;
    repeat (8) tick();
    txr_mode = 2;
    repeat (2*TIMEOUT) tick();
    chk("bp_hold_grant", 32'(grant), 32'b0001);
    chk("bp_pending", 32'(tx_valid), 32'd1);
    txr_mode = 1;
    wait_drain(400);
    txr_mode = 0;
    tick();
    chk("bp_single_grant", 32'(glog.size()), 32'd1);

    // Mid-line reset after the third byte of a 10-byte line.
    glog.delete();
    for (int k = 0; k < 9; k++) push_line(0, 8'(8'h30 + k));
    push_line(0, 8'h0A);
    redrive();
    base = txcnt;
    n = 0;
    while (txcnt < base + 3 && n < 40) begin tick(); n++; end
    chk("mr_pending", 32'(tx_valid), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk_reset_outputs("mr");
    rq[0].delete();
    exp_q.delete();
    redrive();
    tick();
    tick();
    rst = 1'b0;
    glog.delete();
    push_line(0, 8'h50); push_line(0, 8'h0A);
    push_line(2, 8'h51); push_line(2, 8'h0A);
    redrive();
    wait_drain(40);
    chk("mr_grants", 32'(glog.size()), 32'd2);
    if (glog.size() >= 2) begin
      chk("mr_first_grant", 32'(glog[0]), 32'b0001);
      chk("mr_second_grant", 32'(glog[1]), 32'b0100);
    end
    repeat (3) tick();
    chk("end_idle_busy", 32'(busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
